io_platform: RTL

- Platform I/O block that sits directly downstream of the CPU core's I/O port and consumes io_port, data_out and data_out_valid.
- Implements the reserved stdio and interrupt ports:
  - 0: halt.
  - 2: stdin.
  - 3: stdout.
  - 4: interrupt status.
  - 5: interrupt mask.
  - 32: platform status.
- Returns read data combinationally on data_in and drives the core's irq.
- Bridges to an external byte-stream host through an RX FIFO and a TX FIFO.

---
 rtl/io_map.sv | 21 ++
 rtl/byte_fifo.sv | 68 ++++++
 rtl/io_platform.sv | 136 +++++++++++++
 3 files changed

// File: rtl/io_map.sv
// Shared I/O map for the platform block: reserved port numbers, interrupt bit
// positions and status-register bit positions used by the core-facing decoder.
package io_map;

   localparam logic [8:0] PORT_HALT        = 9'd0;
   localparam logic [8:0] PORT_IRQ_VECTOR  = 9'd1;
   localparam logic [8:0] PORT_STDIN       = 9'd2;
   localparam logic [8:0] PORT_STDOUT      = 9'd3;
   localparam logic [8:0] PORT_IRQ_STATUS  = 9'd4;
   localparam logic [8:0] PORT_IRQ_MASK    = 9'd5;
   localparam logic [8:0] PORT_PLAT_STATUS = 9'd32;

   localparam int IRQ_STDIN  = 0;
   localparam int IRQ_STDOUT = 1;

   localparam int OVF_RX = 0;
   localparam int OVF_TX = 1;

   localparam logic [15:0] STDIN_EMPTY = 16'h8000;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with a combinational head and next-cycle fill level,
// so the parent can register an interrupt that tracks the post-edge state.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only safe when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   assign level_next = count_next;

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/io_platform.sv
// Platform I/O block behind the core's I/O port: halt, stdin/stdout byte
// streams, interrupt status/mask and sticky overflow flags.
module io_platform
   import io_map::*;
#(
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [8:0]  io_port,
   input  logic [15:0] data_out,
   input  logic        data_out_valid,
   output logic [15:0] data_in,
   output logic        irq,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;

   logic [15:0]      mask_reg;
   logic [15:0]      mask_next;
   logic             rx_ovf_reg;
   logic             tx_ovf_reg;
   logic             halted_reg;
   logic             irq_reg;

   logic             wr_halt;
   logic             wr_stdin;
   logic             wr_stdout;
   logic             wr_mask;
   logic             wr_status;

   logic [7:0]       rx_head;
   logic             rx_empty;
   logic             rx_full;
   logic [RX_CW-1:0] rx_level_next;
   logic             rx_drop;

   logic             tx_empty;
   logic             tx_full;
   logic [TX_CW-1:0] tx_level_next;
   logic             tx_pop;
   logic             tx_drop;

   logic [15:0]      raw;
   logic [15:0]      raw_next;

   assign wr_halt   = data_out_valid && (io_port == PORT_HALT);
   assign wr_stdin  = data_out_valid && (io_port == PORT_STDIN);
   assign wr_stdout = data_out_valid && (io_port == PORT_STDOUT);
   assign wr_mask   = data_out_valid && (io_port == PORT_IRQ_MASK);
   assign wr_status = data_out_valid && (io_port == PORT_PLAT_STATUS);

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (rx_valid),
      .pop        (wr_stdin),
      .din        (rx_byte),
      .dout       (rx_head),
      .empty      (rx_empty),
      .full       (rx_full),
      .level_next (rx_level_next)
   );

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (wr_stdout),
      .pop        (tx_pop),
      .din        (data_out[7:0]),
      .dout       (tx_byte),
      .empty      (tx_empty),
      .full       (tx_full),
      .level_next (tx_level_next)
   );

   assign tx_valid = !tx_empty;
   assign tx_pop   = tx_valid && tx_ready;
   // A full FIFO is never empty, so a pop request here always frees a slot.
   assign rx_drop  = rx_valid && rx_full && !wr_stdin;
   assign tx_drop  = wr_stdout && tx_full && !tx_pop;

   assign mask_next = wr_mask ? data_out : mask_reg;

   always_comb begin
      raw                  = 16'h0000;
      raw[IRQ_STDIN]       = !rx_empty;
      raw[IRQ_STDOUT]      = !tx_full;
      raw_next             = 16'h0000;
      raw_next[IRQ_STDIN]  = (rx_level_next != '0);
      raw_next[IRQ_STDOUT] = (tx_level_next != TX_CW'(TX_DEPTH));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mask_reg   <= 16'h0000;
         rx_ovf_reg <= 1'b0;
         tx_ovf_reg <= 1'b0;
         halted_reg <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         mask_reg <= mask_next;
         // Sticky flags: a new overflow beats a simultaneous clear.
         rx_ovf_reg <= rx_drop || (rx_ovf_reg && !(wr_status && data_out[OVF_RX]));
         tx_ovf_reg <= tx_drop || (tx_ovf_reg && !(wr_status && data_out[OVF_TX]));
         if (wr_halt) begin
            halted_reg <= 1'b1;
         end
         irq_reg <= |(raw_next & mask_next);
      end
   end

   always_comb begin
      data_in = 16'h0000;
      case (io_port)
         PORT_STDIN:       data_in = rx_empty ? STDIN_EMPTY : {8'h00, rx_head};
         PORT_STDOUT:      data_in = tx_full ? 16'h0000 : 16'h0001;
         PORT_IRQ_STATUS:  data_in = raw & mask_reg;
         PORT_IRQ_MASK:    data_in = mask_reg;
         PORT_PLAT_STATUS: data_in = {14'b0, tx_ovf_reg, rx_ovf_reg};
         default:          data_in = 16'h0000;
      endcase
   end

   assign irq    = irq_reg;
   assign halted = halted_reg;

endmodule
